// File: rtl/stream_scheduler.sv
// stream_scheduler: frames the ADC sample stream into packets for the
// ping-pong buffer writer, handles clean start/stop with optional PPS
// alignment, and paces status requests on a stretched cmd_ready pulse.
module stream_scheduler #(
  parameter int CMD_HOLD  = 16,
  parameter int MIN_WORDS = 24,
  parameter int MAX_WORDS = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] sample_data,
  input  logic        sample_valid,
  input  logic        enable,
  input  logic        start_on_pps,
  input  logic        pps,
  input  logic [9:0]  packet_words,
  input  logic [15:0] status_every,
  input  logic        status_now,
  output logic [15:0] source_data,
  output logic        source_en,
  output logic        source_packet_end,
  output logic        cmd_ready,
  output logic [31:0] packet_total,
  output logic        busy
);

  localparam int HW = (CMD_HOLD > 1) ? $clog2(CMD_HOLD) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ARM, ST_STREAM, ST_DRAIN} state_e;
  typedef enum logic [1:0] {RQ_LOW, RQ_HIGH, RQ_GAP} req_e;

  state_e      state_q, state_d;
  req_e        req_q;
  logic        pps_q;
  logic [9:0]  wc_q, len_q;
  logic [9:0]  len_now, len_eff;
  logic [10:0] pw_ext;
  logic        accept, last, pkt_done;
  logic [15:0] src_data_q;
  logic        src_en_q, src_end_q, busy_q, cmd_q;
  logic [31:0] total_q;
  logic [15:0] div_q, div_d, se_q;
  logic        status_req, new_req, pending_q;
  logic [HW-1:0] hold_q;

  assign source_data       = src_data_q;
  assign source_en         = src_en_q;
  assign source_packet_end = src_end_q;
  assign cmd_ready         = cmd_q;
  assign packet_total      = total_q;
  assign busy              = busy_q;

  // Packet length clamp, word acceptance and next framing state
  always_comb begin
    pw_ext = {1'b0, packet_words};
    if (pw_ext < 11'(MIN_WORDS))      len_now = 10'(MIN_WORDS);
    else if (pw_ext > 11'(MAX_WORDS)) len_now = 10'(MAX_WORDS);
    else                              len_now = packet_words;
    len_eff = (wc_q == '0) ? len_now : len_q;
    last    = (wc_q == len_eff - 10'd1);
    accept  = 1'b0;
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (enable) state_d = start_on_pps ? ST_ARM : ST_STREAM;
      ST_ARM: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (pps && !pps_q) begin
          state_d = ST_STREAM;
          accept  = sample_valid;
        end
      end
      ST_STREAM: begin
        if (enable) begin
          accept = sample_valid;
        end else if (wc_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          // Stop mid-packet: keep this word, finish the packet in DRAIN
          // unless this very word closes it.
          accept  = sample_valid;
          state_d = (sample_valid && last) ? ST_IDLE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        accept = sample_valid;
        if (sample_valid && last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    pkt_done = accept && last;
  end

  // Framing FSM with registered buffer-writer outputs and packet counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      pps_q      <= 1'b0;
      wc_q       <= '0;
      len_q      <= '0;
      src_data_q <= '0;
      src_en_q   <= 1'b0;
      src_end_q  <= 1'b0;
      busy_q     <= 1'b0;
      total_q    <= '0;
    end else begin
      state_q    <= state_d;
      pps_q      <= pps;
      src_en_q   <= accept;
      src_data_q <= accept ? sample_data : '0;
      src_end_q  <= pkt_done;
      busy_q     <= (state_d != ST_IDLE);
      if (accept) begin
        if (wc_q == '0) len_q <= len_now;
        wc_q <= last ? '0 : wc_q + 10'd1;
      end
      if (pkt_done) total_q <= total_q + 32'd1;
    end
  end

  // Status divider: request every status_every completed packets
  always_comb begin
    status_req = 1'b0;
    div_d      = div_q;
    if (status_every == '0) begin
      div_d = '0;
    end else if ((status_every != se_q) && (status_every <= div_q)) begin
      div_d = '0;
    end else if (pkt_done) begin
      if (div_q + 16'd1 == status_every) begin
        div_d      = '0;
        status_req = 1'b1;
      end else begin
        div_d = div_q + 16'd1;
      end
    end
    new_req = status_req || status_now;
  end

  // Divider and previous status_every registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q <= '0;
      se_q  <= '0;
    end else begin
      div_q <= div_d;
      se_q  <= status_every;
    end
  end

  // Request engine: CMD_HOLD cycles high, then CMD_HOLD cycles low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_q     <= RQ_LOW;
      hold_q    <= '0;
      cmd_q     <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      pending_q <= pending_q || new_req;
      unique case (req_q)
        RQ_LOW: begin
          if (pending_q) begin
            req_q     <= RQ_HIGH;
            cmd_q     <= 1'b1;
            hold_q    <= '0;
            pending_q <= new_req;
          end
        end
        RQ_HIGH: begin
          if (hold_q == HW'(CMD_HOLD - 1)) begin
            req_q  <= RQ_GAP;
            cmd_q  <= 1'b0;
            hold_q <= '0;
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        RQ_GAP: begin
          if (hold_q == HW'(CMD_HOLD - 1)) begin
            // A request already waiting goes straight back to HIGH so the
            // low gap is exactly CMD_HOLD rather than CMD_HOLD+1.
            hold_q <= '0;
            if (pending_q) begin
              req_q     <= RQ_HIGH;
              cmd_q     <= 1'b1;
              pending_q <= new_req;
            end else begin
              req_q <= RQ_LOW;
            end
          end else begin
            hold_q <= hold_q + 1'b1;
          end
        end
        default: begin
          req_q <= RQ_LOW;
          cmd_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_scheduler.sv
// Testbench for stream_scheduler: directed phases with randomized data and a
// behavioural reference model (packet countdown + time-based request plan).
module tb_stream_scheduler;

  localparam int HOLD = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] sample_data = '0;
  logic        sample_valid = 1'b0;
  logic        enable = 1'b0;
  logic        start_on_pps = 1'b0;
  logic        pps = 1'b0;
  logic [9:0]  packet_words = 10'd100;
  logic [15:0] status_every = 16'd3;
  logic        status_now = 1'b0;
  logic [15:0] source_data;
  logic        source_en;
  logic        source_packet_end;
  logic        cmd_ready;
  logic [31:0] packet_total;
  logic        busy;

  stream_scheduler #(.CMD_HOLD(HOLD), .MIN_WORDS(24), .MAX_WORDS(1023)) dut (
    .clk(clk), .reset_n(reset_n), .sample_data(sample_data),
    .sample_valid(sample_valid), .enable(enable), .start_on_pps(start_on_pps),
    .pps(pps), .packet_words(packet_words), .status_every(status_every),
    .status_now(status_now), .source_data(source_data), .source_en(source_en),
    .source_packet_end(source_packet_end), .cmd_ready(cmd_ready),
    .packet_total(packet_total), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails = 0;

  // Reference model state
  int         m_mode;      // 0 idle, 1 waiting for pps, 2 streaming, 3 draining
  int         m_rem;       // words still owed in the open packet (0 = none open)
  bit [31:0]  m_total;
  int         m_div, m_se_prev;
  bit         m_pps_prev, m_pend;
  longint     cyc = 0, m_hi_start, m_pend_start;
  bit         exp_en, exp_end, exp_busy, exp_cmd;
  logic [15:0] exp_data;
  int         cnt_en, cnt_cmd;

  function automatic int clampw(input int pw);
    return (pw < 24) ? 24 : ((pw > 1023) ? 1023 : pw);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_rem = 0; m_total = 0; m_div = 0; m_se_prev = 0;
    m_pps_prev = 0; m_pend = 0; m_hi_start = cyc - 1000;
    exp_en = 0; exp_end = 0; exp_busy = 0; exp_cmd = 0; exp_data = '0;
  endtask

  task automatic model_edge();
    bit fwd, done, req;
    fwd = 0; done = 0; req = 0;
    cyc++;
    case (m_mode)
      0: if (enable) m_mode = start_on_pps ? 1 : 2;
      1: if (!enable) m_mode = 0;
         else if (pps && !m_pps_prev) begin m_mode = 2; fwd = sample_valid; end
      2: if (enable) fwd = sample_valid;
         else if (m_rem == 0) m_mode = 0;
         else begin fwd = sample_valid; m_mode = 3; end
      default: fwd = sample_valid;
    endcase
    if (fwd) begin
      if (m_rem == 0) m_rem = clampw(int'(packet_words));
      m_rem--;
      done = (m_rem == 0);
    end
    if (done && m_mode == 3) m_mode = 0;
    exp_en = fwd;
    exp_data = fwd ? sample_data : 16'h0;
    exp_end = done;
    if (done) m_total++;
    exp_busy = (m_mode != 0);
    m_pps_prev = pps;
    if (status_every == 0) m_div = 0;
    else if (int'(status_every) != m_se_prev && int'(status_every) <= m_div) m_div = 0;
    else if (done) begin
      m_div++;
      if (m_div == int'(status_every)) begin m_div = 0; req = 1; end
    end
    m_se_prev = int'(status_every);
    if (m_pend && cyc == m_pend_start) begin m_hi_start = cyc; m_pend = 0; end
    if ((req || status_now) && !m_pend) begin
      m_pend = 1;
      m_pend_start = (cyc + 1 > m_hi_start + 2 * HOLD) ? cyc + 1 : m_hi_start + 2 * HOLD;
    end
    exp_cmd = (cyc >= m_hi_start) && (cyc < m_hi_start + HOLD);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("source_en", source_en, exp_en);
    chk("source_packet_end", source_packet_end, exp_end);
    chk("source_data", source_data, exp_data);
    chk("busy", busy, exp_busy);
    chk("cmd_ready", cmd_ready, exp_cmd);
    chk("packet_total", packet_total, m_total);
    cnt_en += int'(source_en);
    cnt_cmd += int'(cmd_ready);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample_valid = 1'b1;
      sample_data = 16'($urandom);
      step();
    end
  endtask

  initial begin
    logic        rec [0:79];
    logic [15:0] d0;
    int          ph, hi1, gap, hi2, rises;

    // Reset state, before any clock edge
    model_reset();
    #3;
    chk("rst_en", source_en, 0);
    chk("rst_data", source_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd", cmd_ready, 0);
    chk("rst_total", packet_total, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // Framing: 100-word packets, continuous valid
    packet_words = 10'd100; status_every = 16'd3; enable = 1'b1;
    step();
    chk("busy_stream", busy, 1);
    for (int k = 0; k < 300; k++) begin
      sample_valid = 1'b1; sample_data = 16'($urandom);
      step();
      if (k == 0) chk("first_en", source_en, 1);
      if (k == 99) chk("total_1", packet_total, 1);
      if (k == 199) chk("total_2", packet_total, 2);
    end
    chk("total_3", packet_total, 3);
    chk("end_300", source_packet_end, 1);

    // Clamp and mid-packet length change; status pulse after packet 3
    cnt_cmd = 0;
    run(1);
    packet_words = 10'd5;
    run(40);
    chk("cmd_hold_16", cnt_cmd, 16);
    run(58);
    chk("pkt4_not_cut", packet_total, 3);
    run(1);
    chk("pkt4_len100", packet_total, 4);
    chk("pkt4_end", source_packet_end, 1);
    run(48);
    chk("clamp24_total", packet_total, 6);
    run(10);
    packet_words = 10'd30;
    run(14);
    chk("change_cur_pkt", packet_total, 7);
    run(29);
    chk("change_next_pre", packet_total, 7);
    run(1);
    chk("change_next_len", packet_total, 8);

    // Clean stop at wc=40 with valid gaps; re-enable during DRAIN ignored
    packet_words = 10'd100;
    for (int k = 0; k < 300 && m_rem != 60; k++) begin
      sample_valid = (k % 3) != 2; sample_data = 16'($urandom);
      step();
    end
    enable = 1'b0;
    cnt_en = 0;
    for (int k = 0; k < 300; k++) begin
      if (k == 5) enable = 1'b1;
      if (k == 15) enable = 1'b0;
      sample_valid = (k % 3) != 2; sample_data = 16'($urandom);
      step();
      if (busy == 1'b0) break;
    end
    chk("drain_words", cnt_en, 60);
    chk("drain_idle", busy, 0);
    cnt_en = 0;
    run(20);
    chk("stop_no_en", cnt_en, 0);

    // PPS-aligned start
    start_on_pps = 1'b1; pps = 1'b0; enable = 1'b1;
    cnt_en = 0;
    run(500);
    chk("arm_no_en", cnt_en, 0);
    chk("arm_busy", busy, 1);
    pps = 1'b1; sample_valid = 1'b1; sample_data = 16'($urandom); d0 = sample_data;
    step();
    chk("pps_first_en", source_en, 1);
    chk("pps_first_data", source_data, d0);
    run(10);
    enable = 1'b0; pps = 1'b0;
    for (int k = 0; k < 300; k++) begin
      run(1);
      if (busy == 1'b0) break;
    end
    chk("pps_drain_idle", busy, 0);
    // Abort while armed
    enable = 1'b1; cnt_en = 0;
    run(20);
    enable = 1'b0;
    run(5);
    chk("arm_abort_en", cnt_en, 0);
    chk("arm_abort_busy", busy, 0);

    // Manual status requests merged during HIGH
    sample_valid = 1'b0;
    for (int k = 0; k < 80; k++) step();
    status_now = 1'b1;
    step();
    rec[0] = cmd_ready;
    for (int i = 1; i < 80; i++) begin
      status_now = (i == 4 || i == 7);
      step();
      rec[i] = cmd_ready;
    end
    status_now = 1'b0;
    ph = 0; hi1 = 0; gap = 0; hi2 = 0; rises = 0;
    for (int i = 0; i < 80; i++) begin
      if (rec[i] && (i == 0 || !rec[i-1])) rises++;
      case (ph)
        0: if (rec[i]) begin ph = 1; hi1 = 1; end
        1: if (rec[i]) hi1++; else begin ph = 2; gap = 1; end
        2: if (!rec[i]) gap++; else begin ph = 3; hi2 = 1; end
        3: if (rec[i]) hi2++; else ph = 4;
        default: ;
      endcase
    end
    chk("now_rises", rises, 2);
    chk("now_hi1", hi1, 16);
    chk("now_gap", gap, 16);
    chk("now_hi2", hi2, 16);

    // status_every lowered to the current divider count: no request
    start_on_pps = 1'b0; packet_words = 10'd5; status_every = 16'd10; enable = 1'b1;
    for (int k = 0; k < 200 && m_total < 12; k++) run(1);
    enable = 1'b0;
    for (int k = 0; k < 80; k++) run(1);
    status_every = (m_div != 0) ? 16'(m_div) : 16'd1;
    cnt_cmd = 0;
    run(40);
    chk("se_change_noreq", cnt_cmd, 0);
    status_every = 16'd3;

    // Asynchronous reset mid-packet at wc=50
    packet_words = 10'd100; enable = 1'b1;
    for (int k = 0; k < 300 && m_rem != 50; k++) run(1);
    reset_n = 1'b0;
    #2;
    chk("arst_en", source_en, 0);
    chk("arst_data", source_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_cmd", cmd_ready, 0);
    chk("arst_total", packet_total, 0);
    model_reset();
    @(posedge clk); #1;
    reset_n = 1'b1;
    step();
    run(99);
    chk("post_rst_99", packet_total, 0);
    run(1);
    chk("post_rst_full", packet_total, 1);
    chk("post_rst_end", source_packet_end, 1);

    // Random soak against the model
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(99) == 0) begin
        enable = ~enable;
        start_on_pps = 1'($urandom_range(1));
      end
      if ($urandom_range(49) == 0) pps = ~pps;
      sample_valid = ($urandom_range(3) != 0);
      sample_data = 16'($urandom);
      if ($urandom_range(199) == 0) packet_words = 10'($urandom_range(60));
      status_now = ($urandom_range(49) == 0);
      if ($urandom_range(499) == 0) status_every = 16'($urandom_range(4));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
